// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_fsm
//  Description : Multicycle MIPS-style control unit. Sequences fetch, decode,
//                memory, execute, branch and (optionally) jump phases and
//                decodes the datapath control strobes from the current state.
//                The MC_JUMP_EN macro adds the JUMP state for opcode 000010;
//                without it that opcode is reported as illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] OpCode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
`ifdef MC_JUMP_EN
    localparam logic [5:0] c_OP_J     = 6'b000010;
`endif

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8
`ifdef MC_JUMP_EN
        ,
        JUMP   = 4'd9
`endif
    } state_t;

    state_t     r_state;
    state_t     w_stateNext;
    logic [5:0] r_opLatched;
    logic       w_decodeIllegal;

    // State register; the opcode is captured while in DECODE so later
    // instruction-register changes cannot redirect MEMADR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FETCH;
            r_opLatched <= 6'b000000;
        end else begin
            r_state <= w_stateNext;
            if (r_state == DECODE) begin
                r_opLatched <= OpCode;
            end
        end
    end

    // Next-state logic and opcode legality check during DECODE.
    always_comb begin
        w_stateNext     = r_state;
        w_decodeIllegal = 1'b0;
        case (r_state)
            FETCH:  w_stateNext = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (OpCode)
                    c_OP_RTYPE:        w_stateNext = EXEC;
                    c_OP_LW, c_OP_SW:  w_stateNext = MEMADR;
                    c_OP_BEQ:          w_stateNext = BRANCH;
`ifdef MC_JUMP_EN
                    c_OP_J:            w_stateNext = JUMP;
`endif
                    default: begin
                        w_stateNext     = FETCH;
                        w_decodeIllegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (r_opLatched == c_OP_LW) begin
                    w_stateNext = MEMRD;
                end else if (r_opLatched == c_OP_SW) begin
                    w_stateNext = MEMWR;
                end else begin
                    w_stateNext = FETCH;
                end
            end
            MEMRD:  w_stateNext = mem_ready ? MEMWB : MEMRD;
            MEMWB:  w_stateNext = FETCH;
            MEMWR:  w_stateNext = mem_ready ? FETCH : MEMWR;
            EXEC:   w_stateNext = RWB;
            RWB:    w_stateNext = FETCH;
            BRANCH: w_stateNext = FETCH;
`ifdef MC_JUMP_EN
            JUMP:   w_stateNext = FETCH;
`endif
            default: w_stateNext = FETCH;
        endcase
    end

    // Control strobes decoded from the current state (and mem_ready in the
    // memory-wait states); reset suppresses completion and write strobes so
    // an abandoned instruction leaves no side effects.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (r_state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = w_decodeIllegal;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            RWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
`ifdef MC_JUMP_EN
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
`endif
            default: begin
                PCWrite = 1'b0;
            end
        endcase
        if (rst) begin
            instr_done = 1'b0;
            illegal_op = 1'b0;
            if (r_state != FETCH) begin
                PCWrite     = 1'b0;
                PCWriteCond = 1'b0;
                MemWrite    = 1'b0;
                RegWrite    = 1'b0;
                IRWrite     = 1'b0;
            end
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_control_fsm
//  Description : Self-checking bench for mc_control_fsm: directed scenarios
//                plus randomized instruction streams checked against a
//                phase-list reference model. Honours MC_JUMP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] OpCode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    int nChecks = 0;
    int nErrors = 0;

    mc_control_fsm dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control word, same field order as expCtrl below.
    logic [17:0] actVec;
    assign actVec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                     IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp,
                     ALUSrcB, instr_done, illegal_op};

    function automatic bit isLegal(logic [5:0] op);
`ifdef MC_JUMP_EN
        if (op == 6'b000010) return 1'b1;
`endif
        return (op == 6'b000000) || (op == 6'b100011) ||
               (op == 6'b101011) || (op == 6'b000100);
    endfunction

    // Expected control word per state, taken from the state output table.
    function automatic logic [17:0] expCtrl(int st, logic mr, logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, done, ill;
        logic [1:0] pcs, aop, asb;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, done, ill} = '0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (st)
            0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1: begin asb = 2'b11; ill = !isLegal(op); end
            2: begin asa = 1; asb = 2'b10; end
            3: begin mrd = 1; iord = 1; end
            4: begin m2r = 1; rw = 1; done = 1; end
            5: begin mwr = 1; iord = 1; done = mr; end
            6: begin asa = 1; aop = 2'b10; end
            7: begin rd = 1; rw = 1; done = 1; end
            8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            9: begin pcw = 1; pcs = 2'b10; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, aop,
                asb, done, ill};
    endfunction

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0; OpCode = 6'b000000;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Reach RWB, hold reset two cycles, and reset out of MEMWR with mem_ready=1.
    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            OpCode = 6'b000000; mem_ready = 1'b1;
            @(posedge clk); #1;
        end
        @(negedge clk);
        nChecks++;
        if (state !== 4'd7) begin
            nErrors++; $display("FAIL reset_pre_rwb: state=%0d expected 7", state);
        end
        rst = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        nChecks++;
        if ({state, MemRead, RegWrite, instr_done} !== {4'd0, 3'b100}) begin
            nErrors++;
            $display("FAIL reset_hold: state=%0d MemRead=%b RegWrite=%b instr_done=%b expected 0/1/0/0",
                     state, MemRead, RegWrite, instr_done);
        end
        nChecks++;
        if ({IRWrite, PCWrite, MemWrite, PCWriteCond} !== 4'b1100) begin
            nErrors++;
            $display("FAIL reset_strobes: IRWrite=%b PCWrite=%b MemWrite=%b PCWriteCond=%b expected 1100",
                     IRWrite, PCWrite, MemWrite, PCWriteCond);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            OpCode = 6'b101011; mem_ready = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        nChecks++;
        if ({state, instr_done} !== {4'd5, 1'b0}) begin
            nErrors++;
            $display("FAIL reset_memwr: state=%0d instr_done=%b expected 5/0", state, instr_done);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        nChecks++;
        if (state !== 4'd0) begin
            nErrors++; $display("FAIL reset_memwr_after: state=%0d expected 0", state);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        int expSt[4];
        expSt = '{0, 1, 6, 7};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            OpCode = 6'b000000; mem_ready = 1'b1;
            @(negedge clk);
            nChecks++;
            if (state !== 4'(expSt[i])) begin
                nErrors++; $display("FAIL rtype_state[%0d]: state=%0d expected %0d", i, state, expSt[i]);
            end
            nChecks++;
            if ({RegWrite, RegDst, instr_done} !== ((i == 3) ? 3'b111 : 3'b000)) begin
                nErrors++;
                $display("FAIL rtype_wb[%0d]: RegWrite/RegDst/instr_done=%b%b%b expected %b",
                         i, RegWrite, RegDst, instr_done, (i == 3) ? 3'b111 : 3'b000);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        int   expSt[8];
        logic mrSeq[8];
        expSt = '{0, 1, 2, 3, 3, 3, 3, 4};
        mrSeq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            OpCode    = (i == 1) ? 6'b100011 : 6'b101011;
            mem_ready = mrSeq[i];
            @(negedge clk);
            nChecks++;
            if (state !== 4'(expSt[i])) begin
                nErrors++; $display("FAIL lw_state[%0d]: state=%0d expected %0d", i, state, expSt[i]);
            end
            nChecks++;
            if (MemtoReg !== (expSt[i] == 4)) begin
                nErrors++; $display("FAIL lw_memtoreg[%0d]: MemtoReg=%b expected %b", i, MemtoReg, expSt[i] == 4);
            end
            nChecks++;
            if (instr_done !== (i == 7)) begin
                nErrors++; $display("FAIL lw_done[%0d]: instr_done=%b expected %b", i, instr_done, i == 7);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        int expSt[3];
        expSt = '{0, 1, 8};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            OpCode = 6'b000100; mem_ready = 1'b1;
            @(negedge clk);
            nChecks++;
            if (state !== 4'(expSt[i])) begin
                nErrors++; $display("FAIL beq_state[%0d]: state=%0d expected %0d", i, state, expSt[i]);
            end
            if (i == 2) begin
                nChecks++;
                if ({PCWriteCond, ALUOp, PCSource, instr_done} !== 6'b1_01_01_1) begin
                    nErrors++;
                    $display("FAIL beq_ctrl: PCWriteCond=%b ALUOp=%b PCSource=%b instr_done=%b expected 1/01/01/1",
                             PCWriteCond, ALUOp, PCSource, instr_done);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        int expSt[3];
        int nIll  = 0;
        int nDone = 0;
        expSt = '{0, 1, 0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            OpCode = 6'b111111; mem_ready = 1'b1;
            @(negedge clk);
            nIll  += int'(illegal_op);
            nDone += int'(instr_done);
            nChecks++;
            if (state !== 4'(expSt[i])) begin
                nErrors++; $display("FAIL illegal_state[%0d]: state=%0d expected %0d", i, state, expSt[i]);
            end
            @(posedge clk); #1;
        end
        nChecks++;
        if (nIll != 1 || nDone != 0) begin
            nErrors++; $display("FAIL illegal_pulse: illegal_op cycles=%0d instr_done cycles=%0d expected 1/0", nIll, nDone);
        end
    endtask

    task automatic test_jump();
        int expSt[3];
`ifdef MC_JUMP_EN
        expSt = '{0, 1, 9};
`else
        expSt = '{0, 1, 0};
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            OpCode = 6'b000010; mem_ready = 1'b1;
            @(negedge clk);
            nChecks++;
            if (state !== 4'(expSt[i])) begin
                nErrors++; $display("FAIL jump_state[%0d]: state=%0d expected %0d", i, state, expSt[i]);
            end
`ifdef MC_JUMP_EN
            if (i == 2) begin
                nChecks++;
                if ({PCWrite, PCSource, instr_done} !== 4'b1_10_1) begin
                    nErrors++;
                    $display("FAIL jump_ctrl: PCWrite=%b PCSource=%b instr_done=%b expected 1/10/1",
                             PCWrite, PCSource, instr_done);
                end
            end
`else
            if (i == 1) begin
                nChecks++;
                if (illegal_op !== 1'b1) begin
                    nErrors++; $display("FAIL jump_illegal: illegal_op=%b expected 1", illegal_op);
                end
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    // Back-to-back random instructions with random memory waits; the model is
    // a per-opcode list of visited phases, where phases 0/3/5 repeat while
    // mem_ready is low and OpCode is only meaningful in the decode phase.
    task automatic test_random();
        int         ph[$];
        logic [5:0] op;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            int idx    = 0;
            int budget = 0;
            case ($urandom_range(0, 5))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            if (!isLegal(op))          ph = '{0, 1};
            else if (op == 6'b000000)  ph = '{0, 1, 6, 7};
            else if (op == 6'b100011)  ph = '{0, 1, 2, 3, 4};
            else if (op == 6'b101011)  ph = '{0, 1, 2, 5};
            else if (op == 6'b000100)  ph = '{0, 1, 8};
            else                       ph = '{0, 1, 9};
            while (idx < ph.size()) begin
                logic mr;
                mr        = ($urandom_range(0, 2) != 0);
                mem_ready = mr;
                OpCode    = (ph[idx] == 1) ? op : 6'($urandom);
                @(negedge clk);
                nChecks++;
                if (state !== 4'(ph[idx])) begin
                    nErrors++;
                    $display("FAIL rand_state: op=%b state=%0d expected %0d", op, state, ph[idx]);
                end
                nChecks++;
                if (actVec !== expCtrl(ph[idx], mr, op)) begin
                    nErrors++;
                    $display("FAIL rand_ctrl: op=%b phase=%0d ctrl=%b expected %b",
                             op, ph[idx], actVec, expCtrl(ph[idx], mr, op));
                end
                if (!((ph[idx] == 0 || ph[idx] == 3 || ph[idx] == 5) && !mr)) idx++;
                @(posedge clk); #1;
                budget++;
                if (budget > 200) begin
                    nErrors++;
                    $display("FAIL rand_timeout: op=%b stuck at phase index %0d", op, idx);
                    idx = ph.size();
                end
            end
            if (nErrors > 20) break;
        end
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; OpCode = 6'b000000;
        @(posedge clk); #1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_jump();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-003 The block SHALL have port OpCode, input, 6 bits, the opcode field of the instruction register.
REQ-004 The block SHALL have port mem_ready, input, 1 bit; 1 means the memory completes the current access this cycle.
REQ-005 The block SHALL have these outputs, each 1 bit: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst.
REQ-006 The block SHALL have these outputs, each 2 bits: PCSource, ALUOp, ALUSrcB.
REQ-007 The block SHALL have output state, 4 bits, the current state encoding for debug.
REQ-008 The block SHALL have output instr_done, 1 bit, pulsed in the final cycle of each retired instruction.
REQ-009 The block SHALL have output illegal_op, 1 bit, pulsed for one cycle when an unsupported opcode is decoded.

Function
REQ-010 States SHALL use this encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9; codes 10-15 SHALL go to FETCH on the next cycle.
REQ-011 Outputs SHALL be decoded from the current state and mem_ready only, never directly from OpCode; every output not listed for a state SHALL be 0, with no x values.
REQ-012 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready.
REQ-013 FETCH SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-014 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-015 DECODE SHALL branch on OpCode: 000000 to EXEC; 100011 and 101011 to MEMADR; 000100 to BRANCH; 000010 to JUMP (macro permitting); any other opcode to FETCH with illegal_op=1.
REQ-016 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD if the latched opcode is lw and to MEMWR if it is sw.
REQ-017 MEMRD SHALL drive MemRead=1, IorD=1, hold while mem_ready=0, and go to MEMWB when mem_ready=1.
REQ-018 MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1, then go to FETCH.
REQ-019 MEMWR SHALL drive MemWrite=1, IorD=1, instr_done=mem_ready, hold while mem_ready=0, and go to FETCH when mem_ready=1.
REQ-020 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RWB.
REQ-021 RWB SHALL drive RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1, then go to FETCH.
REQ-022 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1, then go to FETCH.
REQ-023 JUMP SHALL drive PCWrite=1, PCSource=10, instr_done=1, then go to FETCH.
REQ-024 The opcode SHALL be registered in DECODE and that registered copy SHALL be used in MEMADR, so that OpCode changes after DECODE have no effect.
REQ-025 With mem_ready held at 1, latency from entering FETCH to instr_done SHALL be: R-type 4 cycles, lw 5, sw 4, beq 3, j 3.
REQ-026 mem_ready SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.

Reset
REQ-027 When rst=1 at a rising edge, the next state SHALL be FETCH and the latched opcode SHALL be 000000, regardless of current state or pending memory wait.
REQ-028 While in reset-forced FETCH, outputs SHALL follow REQ-012; no write strobe other than the FETCH-gated IRWrite and PCWrite SHALL be active.
REQ-029 A reset asserted mid-instruction, including during MEMWR, SHALL abandon the instruction with no instr_done pulse.

Configuration
REQ-030 Macro MC_JUMP_EN SHALL control jump support; when defined, opcode 000010 SHALL go to JUMP.
REQ-031 When MC_JUMP_EN is undefined, the JUMP state SHALL not exist, opcode 000010 SHALL be treated as illegal (illegal_op=1, then FETCH), and PCSource=10 SHALL never be driven.

Verification
REQ-032 Bench SHALL check: rst=1 for 2 cycles from state 7 -> state=0, MemRead=1, RegWrite=0, instr_done=0.
REQ-033 Bench SHALL check: OpCode=000000, mem_ready=1 -> states 0,1,6,7; RegWrite=1 and RegDst=1 in cycle 4; instr_done in cycle 4.
REQ-034 Bench SHALL check: OpCode=100011, mem_ready=0 for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4; MemtoReg=1 only in state 4.
REQ-035 Bench SHALL check: OpCode=000100 -> states 0,1,8; PCWriteCond=1, ALUOp=01, PCSource=01 in state 8.
REQ-036 Bench SHALL check: OpCode=111111 -> DECODE then FETCH; illegal_op=1 for exactly one cycle; no instr_done.
REQ-037 Bench SHALL check: OpCode=000010 -> with MC_JUMP_EN, states 0,1,9 and PCWrite=1 with PCSource=10; without it, illegal_op=1.
